// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ byte producers.
// Define UART_ARB_TIMEOUT_EN to add the WAIT_DONE watchdog and sticky timeout_err.
module uart_tx_arbiter #(
    parameter int N_REQ          = 4,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    input  logic [9:0]         cfg_cycles_per_bit,
    output logic [N_REQ-1:0]   ack,
    output logic               uart_start,
    output logic [7:0]         uart_tx_data,
    output logic [9:0]         uart_cycles_per_bit,
    input  logic               uart_tx_done,
    output logic               busy,
    output logic [2:0]         cur_id,
    output logic               frame_done,
    input  logic               err_clr,
    output logic               timeout_err
);

    typedef enum logic [1:0] {IDLE, START, WAIT_DONE, RELEASE} state_t;

    state_t     state;
    state_t     state_next;
    logic [2:0] rr_ptr;
    logic [7:0] req_ext;
    logic       grant_valid;
    logic [2:0] winner;
    logic [3:0] cand;
    logic [7:0] win_data;
    logic       timeout_hit;

    assign req_ext = 8'(req);

    // Scan from farthest to nearest so the first pending index after rr_ptr wins.
    always_comb begin
        grant_valid = 1'b0;
        winner      = 3'd0;
        cand        = 4'd0;
        for (int i = N_REQ; i >= 1; i--) begin
            cand = {1'b0, rr_ptr} + 4'(i);
            if (cand >= 4'(N_REQ)) begin
                cand = cand - 4'(N_REQ);
            end
            if (req_ext[cand[2:0]]) begin
                grant_valid = 1'b1;
                winner      = cand[2:0];
            end
        end
    end

    always_comb begin
        win_data = 8'd0;
        for (int k = 0; k < N_REQ; k++) begin
            if (winner == 3'(k)) begin
                win_data = req_data[8*k +: 8];
            end
        end
    end

`ifdef UART_ARB_TIMEOUT_EN
    logic [15:0] watchdog;

    always_ff @(posedge clk) begin
        if (reset || state_next != WAIT_DONE) begin
            watchdog <= 16'd0;
        end else if (state == WAIT_DONE) begin
            watchdog <= watchdog + 16'd1;
        end
    end

    assign timeout_hit = (state == WAIT_DONE) && !uart_tx_done &&
                         (watchdog == 16'(TIMEOUT_CYCLES - 1));

    // A new timeout outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            timeout_err <= 1'b0;
        end else if (timeout_hit) begin
            timeout_err <= 1'b1;
        end else if (err_clr) begin
            timeout_err <= 1'b0;
        end
    end
`else
    localparam int unused_timeout = TIMEOUT_CYCLES;
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign timeout_hit    = 1'b0;
    assign timeout_err    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (grant_valid) state_next = START;
            START:     state_next = WAIT_DONE;
            WAIT_DONE: if (uart_tx_done || timeout_hit) state_next = RELEASE;
            RELEASE:   if (!uart_tx_done) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        ack        = '0;
        uart_start = 1'b0;
        busy       = (state != IDLE);
        case (state)
            START: begin
                uart_start = 1'b1;
                for (int k = 0; k < N_REQ; k++) begin
                    ack[k] = (cur_id == 3'(k));
                end
            end
            WAIT_DONE: uart_start = 1'b1;
            default:   uart_start = 1'b0;
        endcase
    end

    // Frame fields are captured only on the IDLE->START edge and held until the next capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr              <= 3'(N_REQ - 1);
            uart_tx_data        <= 8'd0;
            uart_cycles_per_bit <= 10'd0;
            cur_id              <= 3'd0;
            frame_done          <= 1'b0;
        end else begin
            frame_done <= (state == WAIT_DONE) && uart_tx_done;
            if (state == IDLE && grant_valid) begin
                rr_ptr              <= winner;
                cur_id              <= winner;
                uart_tx_data        <= win_data;
                uart_cycles_per_bit <= cfg_cycles_per_bit;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: transaction-level reference model, transmitter
// and producer models, directed scenarios plus a randomized run.
module tb_uart_tx_arbiter;

    localparam int N   = 4;
    localparam int TMO = 100;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [8*N-1:0] req_data = '0;
    logic [9:0]     cfg = 10'd0;
    logic [N-1:0]   ack;
    logic           uart_start;
    logic [7:0]     uart_tx_data;
    logic [9:0]     uart_cycles_per_bit;
    logic           uart_tx_done = 1'b0;
    logic           busy;
    logic [2:0]     cur_id;
    logic           frame_done;
    logic           err_clr = 1'b0;
    logic           timeout_err;

    uart_tx_arbiter #(.N_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk                 (clk),
        .reset               (reset),
        .req                 (req),
        .req_data            (req_data),
        .cfg_cycles_per_bit  (cfg),
        .ack                 (ack),
        .uart_start          (uart_start),
        .uart_tx_data        (uart_tx_data),
        .uart_cycles_per_bit (uart_cycles_per_bit),
        .uart_tx_done        (uart_tx_done),
        .busy                (busy),
        .cur_id              (cur_id),
        .frame_done          (frame_done),
        .err_clr             (err_clr),
        .timeout_err         (timeout_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int ack_log[$];

    // Reference model: phase 0 idle, 1 grant cycle, 2 transmitting, 3 waiting for done to clear
    int         m_phase = 0;
    int         m_last  = N - 1;
    int         m_id    = 0;
    logic [7:0] m_data  = 8'd0;
    logic [9:0] m_cpb   = 10'd0;
    bit         m_fd    = 1'b0;
    bit         m_terr  = 1'b0;
    int         m_wd    = 0;

    always @(posedge clk) begin : ref_model
        int w;
        bit hit;
        if (reset) begin
            m_phase = 0; m_last = N - 1; m_id = 0; m_data = 8'd0; m_cpb = 10'd0;
            m_fd = 1'b0; m_terr = 1'b0; m_wd = 0;
        end else begin
            hit  = 1'b0;
            m_fd = 1'b0;
            case (m_phase)
                0: begin
                    w = -1;
                    for (int d = 1; d <= N; d++)
                        if (w < 0 && req[(m_last + d) % N]) w = (m_last + d) % N;
                    if (w >= 0) begin
                        m_last = w; m_id = w; m_data = req_data[8*w +: 8]; m_cpb = cfg;
                        m_phase = 1;
                    end
                end
                1: begin m_phase = 2; m_wd = 0; end
                2: begin
                    if (uart_tx_done) begin m_fd = 1'b1; m_phase = 3; end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (m_wd == TMO - 1) begin hit = 1'b1; m_phase = 3; end
                    else m_wd++;
`endif
                end
                default: if (!uart_tx_done) m_phase = 0;
            endcase
            if (hit) m_terr = 1'b1;
            else if (err_clr) m_terr = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int log_code();
        int c = 0;
        foreach (ack_log[i]) c |= ack_log[i] << (4 * i);
        return c;
    endfunction

    // Transmitter and producer model state
    int tx_cnt = 0, rel_cnt = 0, tx_len = 2, rel_len = 1;
    bit rand_mode = 1'b0;

    task automatic step();
        logic [N-1:0] ea;
        @(negedge clk);
        ea = '0;
        if (m_phase == 1) ea[m_id] = 1'b1;
        check("ack", 32'(ack), 32'(ea));
        check("uart_start", 32'(uart_start), 32'(m_phase == 1 || m_phase == 2));
        check("busy", 32'(busy), 32'(m_phase != 0));
        check("cur_id", 32'(cur_id), 32'(m_id));
        check("uart_tx_data", 32'(uart_tx_data), 32'(m_data));
        check("uart_cycles_per_bit", 32'(uart_cycles_per_bit), 32'(m_cpb));
        check("frame_done", 32'(frame_done), 32'(m_fd));
        check("timeout_err", 32'(timeout_err), 32'(m_terr));
        for (int k = 0; k < N; k++) if (ack[k]) ack_log.push_back(k);

        if (reset) begin
            uart_tx_done = 1'b0; tx_cnt = 0; rel_cnt = 0;
        end else if (uart_start) begin
            rel_cnt = 0;
            if (!uart_tx_done) begin
                if (tx_cnt >= tx_len) uart_tx_done = 1'b1;
                else tx_cnt++;
            end
        end else begin
            tx_cnt = 0;
            if (uart_tx_done) begin
                rel_cnt++;
                if (rel_cnt >= rel_len) uart_tx_done = 1'b0;
            end else if (rand_mode) begin
                tx_len  = $urandom_range(0, 6);
                rel_len = $urandom_range(0, 4);
            end
        end

        for (int k = 0; k < N; k++) begin
            if (ack[k]) req[k] = 1'b0;
            else if (rand_mode) begin
                if (!req[k] && $urandom_range(0, 7) == 0) req[k] = 1'b1;
                else if (req[k] && $urandom_range(0, 63) == 0) req[k] = 1'b0;
            end
        end
        if (rand_mode) begin
            for (int k = 0; k < N; k++) req_data[8*k +: 8] = 8'($urandom);
            cfg     = 10'($urandom);
            err_clr = ($urandom_range(0, 15) == 0);
        end
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while ((busy !== 1'b0 || req != '0) && n < max) begin
            step();
            n++;
        end
        check(name, 32'(n < max), 32'd1);
    endtask

    initial begin
        int n, fd_cnt, rel_cyc, gap;

        // Reset state
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(uart_start), 32'd0);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_data", 32'(uart_tx_data), 32'd0);
        check("rst_cpb", 32'(uart_cycles_per_bit), 32'd0);
        check("rst_cur_id", 32'(cur_id), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_timeout_err", 32'(timeout_err), 32'd0);
        reset = 1'b0;
        step();

        // Round robin from reset pointer
        ack_log.delete(); req = 4'b1111;
        wait_idle(200, "rr1111_done");
        check("rr1111_len", 32'(ack_log.size()), 32'd4);
        check("rr1111_order", 32'(log_code()), 32'h3210);
        ack_log.delete(); req = 4'b1001;
        wait_idle(200, "rr1001a_done");
        check("rr1001a_len", 32'(ack_log.size()), 32'd2);
        check("rr1001a_order", 32'(log_code()), 32'h30);

        // Single request, captured fields must ignore later input changes
        ack_log.delete();
        req_data[7:0] = 8'hA5; cfg = 10'd16; req = 4'b0001;
        step();
        check("single_ack", 32'(ack), 32'h1);
        check("single_data", 32'(uart_tx_data), 32'hA5);
        check("single_cpb", 32'(uart_cycles_per_bit), 32'd16);
        fd_cnt = 0; n = 0;
        while (busy && n < 50) begin
            req_data = 32'($urandom); cfg = 10'($urandom);
            step();
            n++;
            fd_cnt += int'(frame_done);
            check("hold_data", 32'(uart_tx_data), 32'hA5);
            check("hold_cpb", 32'(uart_cycles_per_bit), 32'd16);
        end
        check("single_frame_done", 32'(fd_cnt), 32'd1);
        check("single_busy_end", 32'(busy), 32'd0);

        // rr_ptr now 0: 3 is served before 0
        ack_log.delete(); req = 4'b1001;
        wait_idle(200, "rr1001b_done");
        check("rr1001b_len", 32'(ack_log.size()), 32'd2);
        check("rr1001b_order", 32'(log_code()), 32'h03);

        // Release handshake: done held for 5 cycles after start falls
        ack_log.delete(); rel_len = 5; req = 4'b0011;
        step();
        rel_cyc = 0; gap = 0; n = 0;
        while (ack_log.size() < 2 && n < 100) begin
            step();
            n++;
            if (ack == '0) begin
                if (busy && !uart_start) rel_cyc++;
                if (!busy) gap++;
            end
        end
        check("release_cycles", 32'(rel_cyc), 32'd5);
        check("release_gap", 32'(gap), 32'd1);
        check("release_order", 32'(log_code()), 32'h01);
        wait_idle(200, "release_done");
        rel_len = 1;

        // Reset in the middle of a frame
        tx_len = 1000; req = 4'b0100;
        repeat (4) step();
        check("midrst_pre_start", 32'(uart_start), 32'd1);
        reset = 1'b1; req = 4'b1010;
        step();
        check("midrst_start", 32'(uart_start), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        reset = 1'b0; tx_len = 2;
        step();
        check("midrst_grant", 32'(ack), 32'b0010);
        wait_idle(200, "midrst_done");

`ifdef UART_ARB_TIMEOUT_EN
        // Watchdog: transmitter never reports done
        tx_len = 1000000; req = 4'b0001; fd_cnt = 0;
        step();
        n = 0;
        while (uart_start && n < 300) begin
            step();
            fd_cnt += int'(frame_done);
            if (uart_start) n++;
        end
        check("tmo_wait_cycles", 32'(n), 32'(TMO));
        check("tmo_err_set", 32'(timeout_err), 32'd1);
        check("tmo_no_frame_done", 32'(fd_cnt), 32'd0);
        wait_idle(20, "tmo_idle");
        tx_len = 2;
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("tmo_err_clr", 32'(timeout_err), 32'd0);
        step();
`endif

        // Randomized traffic against the model
        rand_mode = 1'b1;
        repeat (3000) step();
        rand_mode = 1'b0; err_clr = 1'b0;
        wait_idle(500, "random_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
